// File: rtl/div_control_unit.sv
// div_control_unit: Moore FSM sequencing an 8-bit MSB-first restoring-division datapath.
// Optional feature macro: DIV_ZERO_CHECK_EN (adds the CHK state and the div_by_zero flag).
module div_control_unit #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IW    = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             NZ,
    input  logic             GE,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             sel_mux_1,
    output logic [1:0]       sel_mux_2,
    output logic [1:0]       sel_mux_3,
    output logic             sel_mux_4,
    output logic [WIDTH-1:0] IMM,
    output logic [IW-1:0]    bit_index,
    output logic [2:0]       alu_operation,
    output logic [1:0]       sel_register_A,
    output logic [1:0]       sel_register_B,
    output logic             write_register_A,
    output logic             write_register_B
);

    localparam logic [2:0] OP_NZ  = 3'd0;
    localparam logic [2:0] OP_SHL = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_GE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHK   = 3'd2,
        S_SHIFT = 3'd3,
        S_CMP   = 3'd4,
        S_SUB   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] qs_set;

    // Quotient Q sits at register 0, remainder R at register 1.
    assign sel_register_A = 2'd0;
    assign sel_register_B = 2'd1;

    // Shadow quotient with the current bit set; written to Q in SUB.
    assign qs_set = qs_q | (WIDTH'(1) << i_q);

`ifdef DIV_ZERO_CHECK_EN
    assign div_by_zero = dz_q;
`else
    logic unused_nz;
    assign unused_nz   = NZ;
    assign div_by_zero = 1'b0;
`endif

    // State, bit counter, shadow quotient and error flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            i_q     <= IW'(WIDTH - 1);
            qs_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            qs_q    <= qs_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d          = state_q;
        i_d              = i_q;
        qs_d             = qs_q;
        dz_d             = dz_q;
        busy             = 1'b1;
        done             = 1'b0;
        sel_mux_1        = 1'b0;
        sel_mux_2        = 2'd0;
        sel_mux_3        = 2'd0;
        sel_mux_4        = 1'b0;
        IMM              = '0;
        bit_index        = '0;
        alu_operation    = OP_NZ;
        write_register_A = 1'b0;
        write_register_B = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_INIT;
                    dz_d    = 1'b0;
                end
            end
            S_INIT: begin
                sel_mux_3        = 2'd2;
                sel_mux_4        = 1'b0;
                write_register_A = 1'b1;
                write_register_B = 1'b1;
                qs_d             = '0;
                i_d              = IW'(WIDTH - 1);
`ifdef DIV_ZERO_CHECK_EN
                state_d          = S_CHK;
`else
                state_d          = S_SHIFT;
`endif
            end
`ifdef DIV_ZERO_CHECK_EN
            S_CHK: begin
                alu_operation = OP_NZ;
                sel_mux_2     = 2'd2;
                if (!NZ) begin
                    state_d = S_DONE;
                    dz_d    = 1'b1;
                end else begin
                    state_d = S_SHIFT;
                end
            end
`endif
            S_SHIFT: begin
                alu_operation    = OP_SHL;
                sel_mux_1        = 1'b1;
                sel_mux_2        = 2'd0;
                bit_index        = i_q;
                sel_mux_4        = 1'b1;
                write_register_B = 1'b1;
                state_d          = S_CMP;
            end
            S_CMP: begin
                alu_operation = OP_GE;
                sel_mux_1     = 1'b1;
                sel_mux_2     = 2'd2;
                bit_index     = i_q;
                if (GE) begin
                    state_d = S_SUB;
                end else if (i_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q - IW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_SUB: begin
                alu_operation    = OP_SUB;
                sel_mux_1        = 1'b1;
                sel_mux_2        = 2'd2;
                bit_index        = i_q;
                sel_mux_4        = 1'b1;
                write_register_B = 1'b1;
                IMM              = qs_set;
                sel_mux_3        = 2'd2;
                write_register_A = 1'b1;
                qs_d             = qs_set;
                if (i_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q - IW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_control_unit.sv
// Bench for div_control_unit: behavioural datapath around the DUT, results checked against N/D, N%D.
module tb_div_control_unit;

    localparam logic [2:0] OP_NZ  = 3'd0;
    localparam logic [2:0] OP_SHL = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_GE  = 3'd4;
`ifdef DIV_ZERO_CHECK_EN
    localparam int BASE = 19;
`else
    localparam int BASE = 18;
`endif

    logic       CLK, RST, start, NZ, GE;
    logic       busy, done, div_by_zero, sel_mux_1, sel_mux_4;
    logic [1:0] sel_mux_2, sel_mux_3, sel_register_A, sel_register_B;
    logic [7:0] IMM;
    logic [2:0] bit_index, alu_operation;
    logic       write_register_A, write_register_B;

    div_control_unit dut (
        .CLK(CLK), .RST(RST), .start(start), .NZ(NZ), .GE(GE),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2), .sel_mux_3(sel_mux_3),
        .sel_mux_4(sel_mux_4), .IMM(IMM), .bit_index(bit_index),
        .alu_operation(alu_operation), .sel_register_A(sel_register_A),
        .sel_register_B(sel_register_B), .write_register_A(write_register_A),
        .write_register_B(write_register_B)
    );

    always #5 CLK = ~CLK;

    // Behavioural datapath: operand registers, register file, ALU and muxes.
    logic [7:0] nreg, dreg, alu_a, alu_c, alu_res, wdata_a, wdata_b;
    logic [7:0] rf [4];

    always_comb begin
        alu_a = sel_mux_1 ? rf[1] : dreg;
        case (sel_mux_2)
            2'd0:    alu_c = nreg;
            2'd1:    alu_c = rf[0];
            2'd2:    alu_c = dreg;
            default: alu_c = 8'd0;
        endcase
        case (alu_operation)
            OP_NZ:   alu_res = {7'd0, alu_c != 8'd0};
            OP_SHL:  alu_res = {alu_a[6:0], alu_c[bit_index]};
            OP_SUB:  alu_res = alu_a - alu_c;
            OP_GE:   alu_res = {7'd0, alu_a >= alu_c};
            default: alu_res = 8'd0;
        endcase
        NZ = (alu_operation == OP_NZ) && (alu_c != 8'd0);
        GE = (alu_operation == OP_GE) && (alu_a >= alu_c);
        case (sel_mux_3)
            2'd0:    wdata_a = nreg;
            2'd1:    wdata_a = dreg;
            2'd2:    wdata_a = IMM;
            default: wdata_a = 8'd0;
        endcase
        wdata_b = sel_mux_4 ? alu_res : IMM;
    end

    always @(posedge CLK) begin
        if (write_register_A) rf[sel_register_A] <= wdata_a;
        if (write_register_B) rf[sel_register_B] <= wdata_b;
    end

    logic [24:0] outs;
    assign outs = {busy, done, div_by_zero, sel_mux_1, sel_mux_2, sel_mux_3, sel_mux_4,
                   IMM, bit_index, alu_operation, write_register_A, write_register_B};

    int n_checks, n_fail;
    int lat, wa_cnt, busy_bad, shift_seen, timed_out, rst_hit, idle_busy, idle_done;
    int sub_idx[$];

    function automatic int exp_lat(input logic [7:0] n, input logic [7:0] d);
        logic [7:0] q;
        if (d == 8'd0) begin
`ifdef DIV_ZERO_CHECK_EN
            return 3;
`else
            return BASE + 8;
`endif
        end
        q = n / d;
        return BASE + $countones(q);
    endfunction

    // Issue one division; observe one cycle at a time, #1 after each rising edge.
    task automatic run_op(input logic [7:0] n, input logic [7:0] d, input int again_at, input int rst_at);
        int cyc;
        nreg = n; dreg = d;
        lat = 0; wa_cnt = 0; busy_bad = 0; shift_seen = 0; timed_out = 0; rst_hit = 0;
        sub_idx.delete();
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        cyc = 1;
        forever begin
            if (busy !== 1'b1) busy_bad++;
            if (write_register_A === 1'b1) begin
                wa_cnt++;
                if (sel_mux_4 === 1'b1) sub_idx.push_back(int'(bit_index));
            end
            if (alu_operation == OP_SHL && write_register_B === 1'b1) shift_seen++;
            if (cyc == rst_at) begin
                RST = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0;
                rst_hit = 1;
                return;
            end
            if (cyc == again_at) start = 1'b1;
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            @(posedge CLK); #1;
            start = 1'b0;
            cyc++;
            if (cyc > 60) begin
                timed_out = 1;
                break;
            end
        end
        @(posedge CLK); #1;
        start = 1'b0;
        idle_busy = int'(busy);
        idle_done = int'(done);
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++;
        if (outs !== 25'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        n_checks++;
        if (sel_register_A !== 2'd0 || sel_register_B !== 2'd1) begin
            n_fail++; $display("FAIL reset_regsel: got %0d/%0d expected 0/1", sel_register_A, sel_register_B);
        end
        RST = 1'b0;
        @(posedge CLK); #1;
        n_checks++;
        if (outs !== 25'd0) begin
            n_fail++; $display("FAIL idle_outputs: got %h expected 0", outs);
        end
    endtask

    task automatic check_result(input string nm, input logic [7:0] n, input logic [7:0] d);
        logic [7:0] eq, er;
        eq = n / d; er = n % d;
        n_checks++;
        if (timed_out != 0) begin
            n_fail++; $display("FAIL %s_timeout: got no done expected done", nm);
        end
        n_checks++;
        if (rf[0] !== eq || rf[1] !== er) begin
            n_fail++; $display("FAIL %s_qr: got Q=%0d R=%0d expected Q=%0d R=%0d", nm, rf[0], rf[1], eq, er);
        end
        n_checks++;
        if (lat != exp_lat(n, d)) begin
            n_fail++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat(n, d));
        end
        n_checks++;
        if (busy_bad != 0 || idle_busy != 0 || idle_done != 0) begin
            n_fail++; $display("FAIL %s_busy: got bad=%0d idle_busy=%0d idle_done=%0d expected 0/0/0", nm, busy_bad, idle_busy, idle_done);
        end
    endtask

    task automatic test_directed();
        run_op(8'd100, 8'd7, -1, -1);
        check_result("div_100_7", 8'd100, 8'd7);
        run_op(8'd255, 8'd1, -1, -1);
        check_result("div_255_1", 8'd255, 8'd1);
        n_checks++;
        if (wa_cnt != 9 || sub_idx.size() != 8) begin
            n_fail++; $display("FAIL writeA_255_1: got %0d writes %0d sub expected 9 writes 8 sub", wa_cnt, sub_idx.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (sub_idx[k] != 7 - k) begin
                    n_fail++; $display("FAIL bit_index_sub%0d: got %0d expected %0d", k, sub_idx[k], 7 - k);
                end
            end
        end
        run_op(8'd5, 8'd9, -1, -1);
        check_result("div_5_9", 8'd5, 8'd9);
        n_checks++;
        if (wa_cnt != 1) begin
            n_fail++; $display("FAIL writeA_5_9: got %0d expected 1", wa_cnt);
        end
    endtask

    task automatic test_div_zero();
        run_op(8'd42, 8'd0, -1, -1);
`ifdef DIV_ZERO_CHECK_EN
        n_checks++;
        if (div_by_zero !== 1'b1 || lat != 3 || shift_seen != 0) begin
            n_fail++; $display("FAIL div_zero: got dz=%b lat=%0d shifts=%0d expected dz=1 lat=3 shifts=0", div_by_zero, lat, shift_seen);
        end
        run_op(8'd100, 8'd7, -1, -1);
        n_checks++;
        if (div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL div_zero_clear: got %b expected 0", div_by_zero);
        end
`else
        n_checks++;
        if (rf[0] !== 8'hFF || rf[1] !== 8'd42 || lat != BASE + 8 || div_by_zero !== 1'b0) begin
            n_fail++; $display("FAIL div_zero_off: got Q=%0d R=%0d lat=%0d dz=%b expected Q=255 R=42 lat=%0d dz=0", rf[0], rf[1], lat, div_by_zero, BASE + 8);
        end
`endif
    endtask

    task automatic test_start_while_busy();
        run_op(8'd100, 8'd7, 5, -1);
        check_result("restart_busy", 8'd100, 8'd7);
    endtask

    task automatic test_back_to_back();
        // start held during the DONE cycle must not launch a new run
        run_op(8'd77, 8'd5, exp_lat(8'd77, 8'd5), -1);
        check_result("b2b_first", 8'd77, 8'd5);
        run_op(8'd250, 8'd13, -1, -1);
        check_result("b2b_second", 8'd250, 8'd13);
    endtask

    task automatic test_reset_mid();
        run_op(8'd100, 8'd7, -1, 8);
        n_checks++;
        if (rst_hit != 1 || outs !== 25'd0) begin
            n_fail++; $display("FAIL mid_reset: got hit=%0d outs=%h expected hit=1 outs=0", rst_hit, outs);
        end
        run_op(8'd200, 8'd3, -1, -1);
        check_result("after_reset", 8'd200, 8'd3);
    endtask

    task automatic test_random();
        logic [7:0] n, d;
        for (int t = 0; t < 24; t++) begin
            n = 8'($urandom);
            d = (t % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            run_op(n, d, -1, -1);
            if (d != 8'd0) begin
                check_result("random", n, d);
            end else begin
                n_checks++;
`ifdef DIV_ZERO_CHECK_EN
                if (div_by_zero !== 1'b1 || lat != 3) begin
                    n_fail++; $display("FAIL random_zero: got dz=%b lat=%0d expected dz=1 lat=3", div_by_zero, lat);
                end
`else
                if (rf[0] !== 8'hFF || rf[1] !== n || lat != BASE + 8) begin
                    n_fail++; $display("FAIL random_zero: got Q=%0d R=%0d lat=%0d expected Q=255 R=%0d lat=%0d", rf[0], rf[1], lat, n, BASE + 8);
                end
`endif
            end
        end
    endtask

    initial begin
        CLK = 1'b0; RST = 1'b1; start = 1'b0;
        nreg = 8'd0; dreg = 8'd0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_directed();
        test_div_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
